// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants and types for the multi-channel PWM block.
//   CNT_W_DEF      : default counter / period / duty width
//   PERIOD_RST_DEF : default active period loaded at reset
//   CH_SLICE_W     : width of one channel's slice inside the packed duty bus
//   dir_e          : counter direction, used only by the center-aligned build
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int                   CNT_W_DEF      = 16;
    localparam logic [CNT_W_DEF-1:0] PERIOD_RST_DEF = 16'd999;
    localparam int                   CH_SLICE_W     = CNT_W_DEF;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_ch_cmp.sv
// -----------------------------------------------------------------------------
// pwm_ch_cmp
// One PWM channel: run flag, duty compare and output polarity.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   cnt_i          : shared period counter
//   duty_i         : active duty value of this channel
//   enable_i       : channel run request
//   polarity_i     : 1 = active-low output
//   wrap_i         : high on the last cycle of a period
//   pwm_o          : registered channel output
// -----------------------------------------------------------------------------
module pwm_ch_cmp
    import pwm_pkg::*;
#(
    parameter int CNT_W = CH_SLICE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] duty_i,
    input  logic             enable_i,
    input  logic             polarity_i,
    input  logic             wrap_i,
    output logic             pwm_o
);

    logic run_q;
    logic run_d;
    logic raw;

    // A channel only starts at a period boundary, but stops at once.
    always_comb begin
        run_d = run_q;
        if (!enable_i) begin
            run_d = 1'b0;
        end else if (wrap_i) begin
            run_d = 1'b1;
        end
    end

    // Gating with enable_i makes the output go inactive on the very next edge
    // after enable drops, not one cycle later via run_q.
    assign raw = run_q & enable_i & (cnt_i < duty_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            pwm_o <= 1'b0;
        end else begin
            run_q <= run_d;
            pwm_o <= raw ^ polarity_i;
        end
    end

endmodule

// File: rtl/pwm_multi_ch.sv
// -----------------------------------------------------------------------------
// pwm_multi_ch
// Multi-channel PWM generator with one shared counter and double-buffered
// period/duty configuration that takes effect only at period boundaries.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   enable       : per-channel run enable (starts at next period boundary)
//   polarity     : per-channel, 1 = active-low
//   cfg_load     : one-cycle strobe capturing cfg_period / cfg_duty
//   cfg_period   : new terminal count
//   cfg_duty     : new duties, channel i at [i*CNT_W +: CNT_W]
//   center       : center-aligned counting (only with PWM_CENTER_ALIGN_EN)
//   pwm_out      : registered channel outputs
//   period_tick  : one-cycle pulse in the cycle after each wrap
// Build option: define PWM_CENTER_ALIGN_EN to add the center input and the
// up/down counter; otherwise the block is edge-aligned only.
// -----------------------------------------------------------------------------
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int               NUM_CH     = 4,
    parameter int               CNT_W      = CH_SLICE_W,
    parameter logic [CNT_W-1:0] PERIOD_RST = CNT_W'(PERIOD_RST_DEF)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       polarity,
    input  logic                    cfg_load,
    input  logic [CNT_W-1:0]        cfg_period,
    input  logic [NUM_CH*CNT_W-1:0] cfg_duty,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                    center,
`endif
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_tick
);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        period_act_q, period_act_d;
    logic [CNT_W-1:0]        period_pend_q;
    logic [NUM_CH*CNT_W-1:0] duty_act_q, duty_act_d;
    logic [NUM_CH*CNT_W-1:0] duty_pend_q;
    logic                    pend_q, pend_d;
    logic                    tick_q;
    logic                    wrap;

    // Shadow-to-active transfer. A load landing on the wrap cycle bypasses
    // the shadow so the new values apply to the period that starts next.
    always_comb begin
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        pend_d       = pend_q;
        if (wrap) begin
            if (cfg_load) begin
                period_act_d = cfg_period;
                duty_act_d   = cfg_duty;
                pend_d       = 1'b0;
            end else if (pend_q) begin
                period_act_d = period_pend_q;
                duty_act_d   = duty_pend_q;
                pend_d       = 1'b0;
            end
        end else if (cfg_load) begin
            pend_d = 1'b1;
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    dir_e dir_q, dir_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        dir_d = dir_q;
        wrap  = 1'b0;
        if (!center) begin
            wrap  = (cnt_q == period_act_q);
            dir_d = DIR_UP;
            if (wrap) begin
                cnt_d = '0;
            end
        end else begin
            // Period is 0,1..P,P-1..1 (2*P clocks); the down-count 0 is the
            // wrap and is immediately followed by 1 of the next up-ramp.
            wrap = (period_act_q == '0) || (dir_q == DIR_DOWN && cnt_q == '0);
            if (wrap) begin
                cnt_d = (period_act_d == '0) ? '0 : CNT_W'(1);
                dir_d = DIR_UP;
            end else if (dir_q == DIR_UP && cnt_q == period_act_q) begin
                cnt_d = cnt_q - 1'b1;
                dir_d = DIR_DOWN;
            end else if (dir_q == DIR_DOWN) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= DIR_UP;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    assign wrap  = (cnt_q == period_act_q);
    assign cnt_d = wrap ? '0 : cnt_q + 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            period_act_q  <= PERIOD_RST;
            period_pend_q <= '0;
            duty_act_q    <= '0;
            duty_pend_q   <= '0;
            pend_q        <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            period_act_q <= period_act_d;
            duty_act_q   <= duty_act_d;
            pend_q       <= pend_d;
            tick_q       <= wrap;
            if (cfg_load && !wrap) begin
                period_pend_q <= cfg_period;
                duty_pend_q   <= cfg_duty;
            end
        end
    end

    assign period_tick = tick_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        pwm_ch_cmp #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .cnt_i      (cnt_q),
            .duty_i     (duty_act_q[gi*CNT_W +: CNT_W]),
            .enable_i   (enable[gi]),
            .polarity_i (polarity[gi]),
            .wrap_i     (wrap),
            .pwm_o      (pwm_out[gi])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_ch
// Directed bench for pwm_multi_ch (4 channels, 16-bit, reset period 9).
// Outputs are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_pwm_multi_ch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  enable;
    logic [3:0]  polarity;
    logic        cfg_load;
    logic [15:0] cfg_period;
    logic [63:0] cfg_duty;
`ifdef PWM_CENTER_ALIGN_EN
    logic        center;
`endif
    logic [3:0]  pwm_out;
    logic        period_tick;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_multi_ch #(
        .NUM_CH     (4),
        .CNT_W      (16),
        .PERIOD_RST (16'd9)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .polarity    (polarity),
        .cfg_load    (cfg_load),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
`ifdef PWM_CENTER_ALIGN_EN
        .center      (center),
`endif
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  pol;
        logic [63:0] duty;   // {ch3, ch2, ch1, ch0}
        logic [31:0] hi;     // expected high clocks per 10, byte per channel
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end else begin
            $display("ok   %s: %0h", nm, got);
        end
    endtask

    // Returns on the falling edge where period_tick is seen high.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 200);
        if (!period_tick) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_load();
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    initial begin
        logic [19:0] obs_o, obs_t;
        int          hi [4];
        int          nt, n;

        vecs[0] = '{4'b0001, 4'b0000, {16'd12, 16'd0, 16'd8, 16'd3}, {8'd0, 8'd0,  8'd0,  8'd3}};
        vecs[1] = '{4'b1111, 4'b0000, {16'd12, 16'd0, 16'd8, 16'd3}, {8'd10, 8'd0, 8'd8,  8'd3}};
        vecs[2] = '{4'b1111, 4'b1111, {16'd12, 16'd0, 16'd8, 16'd3}, {8'd0, 8'd10, 8'd2,  8'd7}};
        vecs[3] = '{4'b0101, 4'b0011, {16'd12, 16'd0, 16'd8, 16'd3}, {8'd0, 8'd0,  8'd10, 8'd7}};
        vecs[4] = '{4'b1111, 4'b0000, {16'd5,  16'd1, 16'd10, 16'd9}, {8'd5, 8'd1, 8'd10, 8'd9}};

        rst_n      = 1'b0;
        enable     = 4'b0000;
        polarity   = 4'b1010;
        cfg_load   = 1'b0;
        cfg_period = 16'd9;
        cfg_duty   = '0;
`ifdef PWM_CENTER_ALIGN_EN
        center     = 1'b0;
`endif

        // Reset state and first edge after release.
        repeat (3) @(negedge clk);
        chk("rst_pwm_out", 32'(pwm_out), 32'h0);
        chk("rst_tick", 32'(period_tick), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_edge_polarity", 32'(pwm_out), 32'ha);
        polarity = 4'b0000;

        // Basic waveform: duty 3 of period 9 on ch0, exact cycle placement.
        enable   = 4'b0001;
        cfg_duty = {16'd12, 16'd0, 16'd8, 16'd3};
        do_load();
        wait_tick();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            obs_o[k-1] = pwm_out[0];
            obs_t[k-1] = period_tick;
        end
        chk("basic_ch0_wave", 32'(obs_o[9:0]), 32'h007);
        chk("basic_tick_wave", 32'(obs_t[9:0]), 32'h200);

        // Table: steady-state high counts per 10-clock period.
        for (int v = 0; v < 5; v++) begin
            enable   = vecs[v].en;
            polarity = vecs[v].pol;
            cfg_duty = vecs[v].duty;
            do_load();
            wait_tick();
            wait_tick();
            for (int c = 0; c < 4; c++) hi[c] = 0;
            nt = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
                nt += int'(period_tick);
            end
            for (int c = 0; c < 4; c++)
                chk($sformatf("vec%0d_ch%0d_high", v, c), 32'(hi[c]), 32'(vecs[v].hi[c*8 +: 8]));
            chk($sformatf("vec%0d_ticks", v), 32'(nt), 32'd1);
        end

        // Mid-period duty change on ch1 (3 -> 8): old duty until the wrap.
        enable   = 4'b1111;
        polarity = 4'b0000;
        cfg_duty = {16'd12, 16'd5, 16'd3, 16'd3};
        do_load();
        wait_tick();
        wait_tick();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            obs_o[k-1] = pwm_out[1];
            obs_t[k-1] = period_tick;
            if (k == 4) begin
                cfg_duty[31:16] = 16'd8;
                cfg_load = 1'b1;
            end
            if (k == 5) cfg_load = 1'b0;
        end
        chk("midload_ch1_wave", 32'(obs_o), 32'h3fc07);
        chk("midload_tick_wave", 32'(obs_t), 32'h80200);

        // Two loads in one period: the later one wins.
        wait_tick();
        hi[0] = 0;
        hi[1] = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k <= 10) hi[0] += int'(pwm_out[1]);
            else         hi[1] += int'(pwm_out[1]);
            if (k == 3) begin
                cfg_duty[31:16] = 16'd5;
                cfg_load = 1'b1;
            end
            if (k == 4) cfg_load = 1'b0;
            if (k == 6) begin
                cfg_duty[31:16] = 16'd2;
                cfg_load = 1'b1;
            end
            if (k == 7) cfg_load = 1'b0;
        end
        chk("lastwins_old_high", 32'(hi[0]), 32'd8);
        chk("lastwins_new_high", 32'(hi[1]), 32'd2);

        // enable[2] raised mid-period waits for the wrap; dropping is immediate.
        enable[2] = 1'b0;
        wait_tick();
        wait_tick();
        obs_o = '0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            obs_o[k-1] = pwm_out[2];
            if (k == 3)  enable[2] = 1'b1;
            if (k == 12) enable[2] = 1'b0;
        end
        chk("enable_ch2_wave", 32'(obs_o), 32'h00c00);

        // Load on the wrap cycle itself: period 4 applies straight away.
        wait_tick();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            obs_t[k-1] = period_tick;
            if (k == 9) begin
                cfg_period = 16'd4;
                cfg_load   = 1'b1;
            end
            if (k == 10) cfg_load = 1'b0;
        end
        chk("wrapload_tick_wave", 32'(obs_t), 32'h84200);

        // Reset mid-period discards a pending period and clears outputs at once.
        polarity = 4'b1111;
        wait_tick();
        @(negedge clk);
        cfg_period = 16'd6;
        do_load();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pwm_out", 32'(pwm_out), 32'h0);
        chk("async_rst_tick", 32'(period_tick), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 50);
        chk("rst_period_len", 32'(n), 32'd10);

`ifdef PWM_CENTER_ALIGN_EN
        // Center-aligned: period 4, duty 2 -> 8 clocks, 3 active clocks.
        polarity   = 4'b0000;
        enable     = 4'b1111;
        center     = 1'b1;
        cfg_period = 16'd4;
        cfg_duty   = {16'd2, 16'd2, 16'd2, 16'd2};
        do_load();
        wait_tick();
        wait_tick();
        wait_tick();
        n     = 0;
        hi[0] = 0;
        do begin
            @(negedge clk);
            n++;
            hi[0] += int'(pwm_out[0]);
        end while (!period_tick && n < 50);
        chk("center_period_len", 32'(n), 32'd8);
        chk("center_ch0_high", 32'(hi[0]), 32'd3);
        polarity = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("center_async_rst", 32'(pwm_out), 32'h0);
        rst_n = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
